// File: rtl/switch_debounce_select.sv
// Switch conditioning for the LED blink / frequency-select logic.
// Each raw switch pin is passed through a two-flop synchronizer and then a
// counter debouncer. The block produces clean levels, one-cycle press and
// release pulses, and a 2-bit wrap-around mode register that switch 0
// increments and switch 1 decrements.
module switch_debounce_select #(
  parameter int NUM_SWITCHES     = 4,
  parameter int c_DEBOUNCE_LIMIT = 250000
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NUM_SWITCHES-1:0] i_switch,
  output logic [NUM_SWITCHES-1:0] o_switch,
  output logic [NUM_SWITCHES-1:0] o_press,
  output logic [NUM_SWITCHES-1:0] o_release,
  output logic [1:0]              o_mode
);

  localparam int CW = $clog2(c_DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(c_DEBOUNCE_LIMIT - 1);

  logic [NUM_SWITCHES-1:0] sync_s1;
  logic [NUM_SWITCHES-1:0] sync_s2;
  logic [CW-1:0]           count [NUM_SWITCHES];
  logic [NUM_SWITCHES-1:0] accept;

  // Two-flop synchronizer; only sync_s2 is used downstream.
  always_ff @(posedge i_clock) begin
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes s1 -> s2 a two-stage
    // pipeline instead of a single wire-through.
    if (i_reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= i_switch;
      sync_s2 <= sync_s1;
    end
  end

  // A channel is accepted on the cycle its disagreement has lasted the full limit.
  always_comb begin
    // NOTE: default first so no path through this block leaves accept
    // unassigned, which would otherwise infer a latch.
    accept = '0;
    for (int n = 0; n < NUM_SWITCHES; n++) begin
      accept[n] = (sync_s2[n] != o_switch[n]) && (count[n] == LAST_COUNT);
    end
  end

  // Per-channel debounce counters, debounced levels and registered edge pulses.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_switch  <= '0;
      o_press   <= '0;
      o_release <= '0;
      // NOTE: count is a small array of flops, not a RAM, so clearing it in
      // reset is cheap and required to discard any partially counted bounce.
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        count[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        o_press[n]   <= accept[n] &  sync_s2[n];
        o_release[n] <= accept[n] & ~sync_s2[n];
        if (sync_s2[n] == o_switch[n]) begin
          count[n] <= '0;
        end else if (accept[n]) begin
          o_switch[n] <= sync_s2[n];
          count[n]    <= '0;
        end else begin
          count[n] <= count[n] + CW'(1);
        end
      end
    end
  end

  // Mode register follows the press pulses one cycle later; simultaneous
  // presses on switches 0 and 1 cancel out.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_mode <= 2'd0;
    end else begin
      case ({o_press[1], o_press[0]})
        2'b01:   o_mode <= o_mode + 2'd1;
        2'b10:   o_mode <= o_mode - 2'd1;
        default: o_mode <= o_mode;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debounce_select.sv
// Self-checking bench for switch_debounce_select (4 channels, limit 4).
// A vector table covers reset and the first held-through-reset press,
// directed sequences cover latency, bounce, mode wrap, simultaneous presses
// and reset mid-count, and a randomized phase is checked every cycle against
// a behavioural model.
module tb_switch_debounce_select;

  localparam int N = 4;
  localparam int L = 4;

  logic         i_clock = 1'b0;
  logic         i_reset;
  logic [N-1:0] i_switch;
  logic [N-1:0] o_switch;
  logic [N-1:0] o_press;
  logic [N-1:0] o_release;
  logic [1:0]   o_mode;

  switch_debounce_select #(
    .NUM_SWITCHES    (N),
    .c_DEBOUNCE_LIMIT(L)
  ) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_switch (i_switch),
    .o_switch (o_switch),
    .o_press  (o_press),
    .o_release(o_release),
    .o_mode   (o_mode)
  );

  always #5 i_clock = ~i_clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: the debouncer sees the input from two edges ago and
  // adopts it once it has disagreed with the current level for L edges running.
  int m_d1, m_d2;
  int m_level, m_press, m_rel, m_mode;
  int m_run [N];

  task automatic model_edge(input bit rst, input int x);
    int seen, new_p, new_r;
    if (rst) begin
      m_d1 = 0; m_d2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_mode = 0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
    end else begin
      seen = m_d2;
      if ((m_press & 1) != 0 && (m_press & 2) == 0) m_mode = (m_mode + 1) % 4;
      if ((m_press & 2) != 0 && (m_press & 1) == 0) m_mode = (m_mode + 3) % 4;
      new_p = 0;
      new_r = 0;
      for (int c = 0; c < N; c++) begin
        if (((seen >> c) & 1) != ((m_level >> c) & 1)) begin
          m_run[c]++;
          if (m_run[c] == L) begin
            m_level ^= (1 << c);
            if (((seen >> c) & 1) == 1) new_p |= (1 << c);
            else                        new_r |= (1 << c);
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_press = new_p;
      m_rel   = new_r;
      m_d2    = m_d1;
      m_d1    = x;
    end
  endtask

  logic [N-1:0] sw_now;
  int           watch_ch2;
  int           any_press;

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input bit rst, input logic [N-1:0] sw);
    i_reset  = rst;
    i_switch = sw;
    @(posedge i_clock);
    model_edge(rst, int'(sw));
    #1;
    check("model_switch",  int'(o_switch),  m_level);
    check("model_press",   int'(o_press),   m_press);
    check("model_release", int'(o_release), m_rel);
    check("model_mode",    int'(o_mode),    m_mode);
    watch_ch2 |= int'(o_switch[2] | o_press[2] | o_release[2]);
    any_press |= int'(o_press);
  endtask

  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, sw_now);
  endtask

  // Counts edges until the requested pulse pattern appears, bounded.
  task automatic wait_pulse(input bit is_press, input logic [N-1:0] mask,
                            input int exp_edges, input string name);
    int n = 0;
    do begin
      step(1'b0, sw_now);
      n++;
    end while (((is_press ? o_press : o_release) != mask) && n < 20);
    check(name, n, exp_edges);
  endtask

  // Clean press-and-release on one channel, checking latency and the new mode.
  task automatic press_ch(input int ch, input int exp_mode, input string name);
    sw_now[ch] = 1'b1;
    step(1'b0, sw_now);
    wait_pulse(1'b1, N'(1 << ch), L + 1, {name, "_latency"});
    step(1'b0, sw_now);
    check({name, "_press_cleared"}, int'(o_press), 0);
    check({name, "_mode"}, int'(o_mode), exp_mode);
    sw_now[ch] = 1'b0;
    hold(L + 4);
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] sw;
    logic [N-1:0] e_sw;
    logic [N-1:0] e_p;
    logic [N-1:0] e_r;
    logic [1:0]   e_mode;
  } vec_t;

  vec_t tbl [10];
  int   hold_left [N];
  logic [N-1:0] rnd_sw;
  bit   rnd_rst;
  int   n_edges;

  initial begin
    // Reset held three cycles with all switches pressed, then released.
    for (int i = 0; i < 3; i++)  tbl[i] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'd0};
    for (int i = 3; i < 8; i++)  tbl[i] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[8] = '{1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 2'd0};
    tbl[9] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 2'd0};

    sw_now    = '0;
    watch_ch2 = 0;
    any_press = 0;
    i_reset   = 1'b1;
    i_switch  = '0;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].sw);
      check($sformatf("vec%0d_switch", i),  int'(o_switch),  int'(tbl[i].e_sw));
      check($sformatf("vec%0d_press", i),   int'(o_press),   int'(tbl[i].e_p));
      check($sformatf("vec%0d_release", i), int'(o_release), int'(tbl[i].e_r));
      check($sformatf("vec%0d_mode", i),    int'(o_mode),    int'(tbl[i].e_mode));
    end

    // Release everything: release pulse L+1 edges after the sampling edge.
    sw_now = 4'b0000;
    step(1'b0, sw_now);
    wait_pulse(1'b0, 4'b1111, L + 1, "release_all");
    hold(3);

    // Mode wrap: four increments then one decrement.
    press_ch(0, 1, "wrap1");
    press_ch(0, 2, "wrap2");
    press_ch(0, 3, "wrap3");
    press_ch(0, 0, "wrap0");
    press_ch(1, 3, "dec_wrap");

    // Simultaneous ch0 + ch1 press and release.
    sw_now = 4'b0011;
    step(1'b0, sw_now);
    wait_pulse(1'b1, 4'b0011, L + 1, "simul_press");
    step(1'b0, sw_now);
    check("simul_mode_hold", int'(o_mode), 3);
    sw_now = 4'b0000;
    step(1'b0, sw_now);
    wait_pulse(1'b0, 4'b0011, L + 1, "simul_release");
    hold(3);

    // Bounce on ch2: high 3, low 1, high 2, low; nothing may come out.
    watch_ch2 = 0;
    sw_now[2] = 1'b1; hold(3);
    sw_now[2] = 1'b0; hold(1);
    sw_now[2] = 1'b1; hold(2);
    sw_now[2] = 1'b0; hold(10);
    check("bounce_ch2_quiet", watch_ch2, 0);

    // Reset two cycles after ch1 rises; held switch reappears as a new press.
    any_press = 0;
    sw_now[1] = 1'b1;
    step(1'b0, sw_now);
    hold(2);
    step(1'b1, sw_now);
    step(1'b1, sw_now);
    check("midreset_no_early_press", any_press, 0);
    n_edges = 0;
    do begin
      step(1'b0, sw_now);
      n_edges++;
    end while (o_press != 4'b0010 && n_edges < 20);
    check("midreset_press_latency", n_edges, L + 2);
    step(1'b0, sw_now);
    check("midreset_mode", int'(o_mode), 3);
    sw_now[1] = 1'b0;
    hold(L + 4);

    // Randomized phase: per-channel holds of random length, rare resets.
    for (int c = 0; c < N; c++) hold_left[c] = 0;
    rnd_sw = sw_now;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (hold_left[c] == 0) begin
          rnd_sw[c]    = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 10);
        end else begin
          hold_left[c]--;
        end
      end
      rnd_rst = ($urandom_range(0, 399) == 0);
      step(rnd_rst, rnd_sw);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
